// File: rtl/boot_mem_shadow.sv
// boot_mem_shadow: a flop-based boot memory made of two regions.
// The lower ROM_DEPTH words hold a write-protected boot image that is
// loaded at reset. The upper words are general RAM.
// It has a registered read port, a sticky write-error flag and a restore
// sequencer that rewrites the protected region from the image.
module boot_mem_shadow #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 12,
  parameter int ROM_DEPTH = 7,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT_IMAGE = {
    {8{16'h0000}},
    16'h0008, 16'h4000, 16'h6007, 16'hB007,
    16'hF400, 16'hF800, 16'h4000, 16'hF200}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              unlock,
  input  logic              restore,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  output logic              ready,
  output logic              busy,
  output logic              wr_err
);

  typedef enum logic {IDLE = 1'b0, RESTORE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                rvalid_q, rvalid_d;
  logic                wr_err_q, wr_err_d;

  logic acc_wr, acc_rd, in_rom, mapped, wr_ok;

  // ready depends only on the sequencer state.
  assign busy   = (state_q == RESTORE);
  assign ready  = ~busy;
  assign dout   = dout_q;
  assign rvalid = rvalid_q;
  assign wr_err = wr_err_q;

  // Decode the bus access and its protection.
  always_comb begin
    acc_wr = cs & we & ready;
    acc_rd = cs & ~we & ready;
    in_rom = (32'(addr) < ROM_DEPTH);
    mapped = (32'(addr) < DEPTH);
    wr_ok  = mapped & (~in_rom | unlock);
  end

  // Next state for the sequencer, the array, the read port and the error flag.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    wr_err_d = wr_err_q;

    case (state_q)
      IDLE: begin
        if (restore) begin
          state_d  = RESTORE;
          cnt_d    = '0;
          wr_err_d = 1'b0;
        end
      end
      RESTORE: begin
        for (int k = 0; k < ROM_DEPTH; k++)
          if (32'(cnt_q) == k) mem_d[k] = INIT_IMAGE[k*DATA_W +: DATA_W];
        cnt_d = cnt_q + 1'b1;
        if (32'(cnt_q) == ROM_DEPTH - 1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A dropped write sets the error flag after the restore-start clear.
    // The set therefore wins when both happen in the same cycle.
    if (acc_wr) begin
      if (wr_ok) begin
        for (int k = 0; k < DEPTH; k++)
          if (32'(addr) == k) mem_d[k] = din;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    if (acc_rd) begin
      rvalid_d = 1'b1;
      dout_d   = '0;
      for (int k = 0; k < DEPTH; k++)
        if (32'(addr) == k) dout_d = mem_q[k];
    end
  end

  // State register. Reset reloads the image and aborts any restore.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        mem_q[k] <= INIT_IMAGE[k*DATA_W +: DATA_W];
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      wr_err_q <= wr_err_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_boot_mem_shadow.sv
// Directed testbench for boot_mem_shadow using hand-computed expected values.
module tb_boot_mem_shadow;

  logic        clk = 1'b0;
  logic        rst, cs, we, unlock, restore;
  logic [3:0]  addr;
  logic [15:0] din, dout;
  logic        rvalid, ready, busy, wr_err;

  int checks = 0;
  int failures = 0;

  boot_mem_shadow dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .unlock(unlock), .restore(restore), .dout(dout), .rvalid(rvalid),
    .ready(ready), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic u);
    cs = 1; we = 1; addr = a; din = d; unlock = u;
    cyc();
    cs = 0; we = 0; unlock = 0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [15:0] d, output logic v);
    cs = 1; we = 0; addr = a;
    cyc();
    d = dout; v = rvalid;
    cs = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin cyc(); n++; end
    checks++;
    if (busy) begin failures++; $display("FAIL wait_idle timeout busy=%b expected 0", busy); end
  endtask

  task automatic test_reset();
    logic [15:0] exp_w [8] = '{16'hF200, 16'h4000, 16'hF800, 16'hF400,
                               16'hB007, 16'h6007, 16'h4000, 16'h0008};
    int rv_cnt = 0;
    rst = 1; cs = 0; we = 0; addr = 0; din = 0; unlock = 0; restore = 0;
    #12;
    checks++;
    if ({dout, rvalid, busy, wr_err, ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state dout=%h rv=%b busy=%b err=%b rdy=%b expected 0000 0 0 0 1",
               dout, rvalid, busy, wr_err, ready);
    end
    rst = 0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      cs = 1; we = 0; addr = 4'(i);
      cyc();
      if (rvalid) rv_cnt++;
      checks++;
      if (dout !== exp_w[i] || rvalid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_read[%0d] dout=%h rv=%b expected %h 1", i, dout, rvalid, exp_w[i]);
      end
    end
    cs = 0;
    cyc();
    checks++;
    if (rv_cnt != 8 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rvalid count=%0d tail=%b expected 8 0", rv_cnt, rvalid);
    end
  endtask

  task automatic test_protect();
    logic [15:0] d; logic v;
    do_write(4'd3, 16'h1234, 1'b0);
    checks++;
    if (wr_err !== 1'b1) begin failures++; $display("FAIL protect_err wr_err=%b expected 1", wr_err); end
    do_read(4'd3, d, v);
    checks++;
    if (d !== 16'hF400 || v !== 1'b1) begin failures++; $display("FAIL protect_read dout=%h rv=%b expected F400 1", d, v); end
    do_write(4'd9, 16'h1234, 1'b0);
    do_read(4'd9, d, v);
    checks++;
    if (d !== 16'h1234) begin failures++; $display("FAIL ram_write dout=%h expected 1234", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic v;
    do_write(4'd10, 16'h5555, 1'b0);
    do_read(4'd10, d, v);
    checks++;
    if (d !== 16'h5555 || v !== 1'b1) begin failures++; $display("FAIL wr_then_rd dout=%h rv=%b expected 5555 1", d, v); end
  endtask

  task automatic test_unlock_restore();
    logic [15:0] d; logic v;
    int n = 0;
    do_write(4'd2, 16'hABCD, 1'b1);
    do_read(4'd2, d, v);
    checks++;
    if (d !== 16'hABCD) begin failures++; $display("FAIL unlock_write dout=%h expected ABCD", d); end
    restore = 1;
    cyc();
    restore = 0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || wr_err !== 1'b0) begin
      failures++;
      $display("FAIL restore_start busy=%b rdy=%b err=%b expected 1 0 0", busy, ready, wr_err);
    end
    while (busy && n < 20) begin n++; cyc(); end
    checks++;
    if (n != 7) begin failures++; $display("FAIL restore_len busy_cycles=%0d expected 7", n); end
    do_read(4'd2, d, v);
    checks++;
    if (d !== 16'hF800) begin failures++; $display("FAIL restore_rom dout=%h expected F800", d); end
    do_read(4'd9, d, v);
    checks++;
    if (d !== 16'h1234) begin failures++; $display("FAIL restore_ram dout=%h expected 1234", d); end
  endtask

  task automatic test_stall();
    int n = 0;
    int bad = 0;
    restore = 1;
    cyc();
    restore = 0;
    cs = 1; we = 0; addr = 4'd5;
    while (busy && n < 20) begin
      if (rvalid) bad++;
      cyc(); n++;
    end
    checks++;
    if (bad != 0 || rvalid !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL stall rvalid_while_busy=%0d rv=%b rdy=%b expected 0 0 1", bad, rvalid, ready);
    end
    cyc();
    cs = 0;
    checks++;
    if (dout !== 16'h6007 || rvalid !== 1'b1) begin
      failures++;
      $display("FAIL stall_read dout=%h rv=%b expected 6007 1", dout, rvalid);
    end
  endtask

  task automatic test_err_race();
    // Restore start and a dropped write in the same cycle: the set wins.
    cs = 1; we = 1; addr = 4'd1; din = 16'hDEAD; unlock = 0; restore = 1;
    cyc();
    cs = 0; we = 0; restore = 0;
    checks++;
    if (wr_err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_race wr_err=%b busy=%b expected 1 1", wr_err, busy);
    end
    wait_idle();
  endtask

  task automatic test_unmapped();
    logic [15:0] d; logic v;
    restore = 1; cyc(); restore = 0;
    wait_idle();
    checks++;
    if (wr_err !== 1'b0) begin failures++; $display("FAIL err_cleared wr_err=%b expected 0", wr_err); end
    do_write(4'd14, 16'h7777, 1'b1);
    checks++;
    if (wr_err !== 1'b1) begin failures++; $display("FAIL unmapped_err wr_err=%b expected 1", wr_err); end
    do_read(4'd14, d, v);
    checks++;
    if (d !== 16'h0000 || v !== 1'b1) begin failures++; $display("FAIL unmapped_read dout=%h rv=%b expected 0000 1", d, v); end
  endtask

  task automatic test_reset_mid_restore();
    logic [15:0] d; logic v;
    do_write(4'd2, 16'hABCD, 1'b1);
    restore = 1; cyc(); restore = 0;
    cyc(); cyc(); cyc();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_restore_busy busy=%b expected 1", busy); end
    rst = 1;
    #1;
    checks++;
    if ({dout, rvalid, busy, wr_err, ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset dout=%h rv=%b busy=%b err=%b rdy=%b expected 0000 0 0 0 1",
               dout, rvalid, busy, wr_err, ready);
    end
    #2;
    rst = 0;
    do_read(4'd2, d, v);
    checks++;
    if (d !== 16'hF800) begin failures++; $display("FAIL reload_rom dout=%h expected F800", d); end
    do_read(4'd9, d, v);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL reload_ram dout=%h expected 0000", d); end
  endtask

  initial begin
    test_reset();
    test_protect();
    test_back_to_back();
    test_unlock_restore();
    test_stall();
    test_err_race();
    test_unmapped();
    test_reset_mid_restore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_mem_shadow.md
# boot_mem_shadow

Parametrised boot memory for the SoC: a flop-based word array whose lower ROM_DEPTH words hold a write-protected boot image loaded asynchronously at reset, and whose upper words are general RAM. It adds a registered read port with a valid strobe, an unlock input for patching the image, a sticky write-error flag, and a restore sequencer that rewrites the protected region from the image while stalling the bus. It sits between the CPU/SPI bus decoder and the boot-time fetch path, taking the place of the fixed 16-word boot ROM.

## Interface
- DATA_W, 16: word width in bits.
- ADDR_W, 4: address width in bits.
- DEPTH, 12: implemented words, 1..2^ADDR_W; addresses >= DEPTH are unmapped.
- ROM_DEPTH, 7: protected words, 0..ROM_DEPTH-1; ROM_DEPTH <= DEPTH.
- INIT_IMAGE, DATA_W*2^ADDR_W bits: word k at bits [k*DATA_W +: DATA_W]. Default words 0-7 are F200, 4000, F800, F400, B007, 6007, 4000, 0008; all others are 0.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- cs, in, 1: access request.
- we, in, 1: 1 = write, 0 = read.
- addr, in, ADDR_W: word address.
- din, in, DATA_W: write data.
- unlock, in, 1: level; 1 permits writes to the protected region.
- restore, in, 1: single-cycle pulse; starts the restore sequence.
- dout, out, DATA_W: registered read data; holds its value between reads.
- rvalid, out, 1: one-cycle strobe, asserted in the cycle dout is updated.
- ready, out, 1: combinational ~busy; an access is accepted only when cs & ready.
- busy, out, 1: restore sequence running.
- wr_err, out, 1: sticky flag; a write was dropped.

## Operation
- Reset, asynchronous: mem[k] = INIT_IMAGE word k for every k < DEPTH. dout=0, rvalid=0, busy=0, wr_err=0, state=IDLE, restore counter=0.
- Accepted write (cs & we & ready):
  - Address < ROM_DEPTH with unlock=1, or ROM_DEPTH <= address < DEPTH: mem[addr] <= din.
  - Address < ROM_DEPTH with unlock=0, or address >= DEPTH: the write is dropped and wr_err <= 1.
- Accepted read (cs & ~we & ready): on the next edge, dout <= mem[addr] (0 if addr >= DEPTH) and rvalid <= 1. In any other cycle rvalid <= 0 and dout holds.
- The restore state machine has two states, IDLE and RESTORE:
  - IDLE, restore=1: go to RESTORE, cnt <= 0, wr_err <= 0. An access accepted in the same cycle still completes.
  - RESTORE: mem[cnt] <= INIT_IMAGE word cnt and cnt <= cnt+1. When cnt == ROM_DEPTH-1, write that word and return to IDLE.
  - A restore pulse while in RESTORE is ignored. RAM words (>= ROM_DEPTH) are never touched by restore.
- busy=1 exactly while in RESTORE. With ready=0, cs is ignored; the requester holds cs/we/addr/din until ready=1.
- Protection applies only to bus writes. The sequencer writes regardless of unlock.

## Timing
- Read latency is 1 cycle: request at edge N is accepted, and dout/rvalid are valid after edge N+1.
- Back-to-back reads are sustained at one per cycle; rvalid stays high continuously.
- A write takes effect at the accepting edge. A read of the same address on the following cycle returns the new data.
- Restore takes ROM_DEPTH cycles of busy=1. ready returns high in the cycle after the last word is written.
- Reset mid-restore aborts the sequence: busy=0 and the array reloads asynchronously.
- wr_err is set at the edge of the offending write and cleared only by reset or by a restore start. A restore start and a dropped write in the same cycle leave wr_err=1, because the set wins.
- No combinational path from cs/addr to dout. ready depends only on state.

## Test plan
- Reset, then read addresses 0-7 back-to-back: dout returns F200, 4000, F800, F400, B007, 6007, 4000, 0008, each one cycle after its request, and rvalid is high for 8 cycles.
- Write 1234 to addr 3 with unlock=0, then read addr 3: the read returns F400 and wr_err=1. Write 1234 to addr 9: reading addr 9 returns 1234.
- Write ABCD to addr 2 with unlock=1, then read: the read returns ABCD. Pulse restore: busy is high for exactly 7 cycles, wr_err=0, addr 2 reads F800, and addr 9 still reads 1234.
- During restore, hold cs=1, we=0, addr=5: no rvalid while busy. After ready rises, the read is accepted, giving dout=6007 one cycle later.
- Write to addr 14 (>= DEPTH): wr_err=1. Reading addr 14 returns 0000 with rvalid=1.
- Assert rst during the 4th restore cycle: all outputs return to reset values immediately, and addr 2 reads F800 after release.
